// File: rtl/cdc_handshake_tx_pkg.sv
// Shared types and defaults for the B->A four-phase handshake transmitter.
package cdc_handshake_tx_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/cdc_bit_sync_n.sv
// N-flop single-bit synchronizer, async active-high reset to 0.
// Latency: STAGES clock edges; no backpressure.
module cdc_bit_sync_n
  import cdc_handshake_tx_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Four-phase req/ack transmitter holding a word in clk_b flops while req_a crosses to domain A.
// Accept-to-req_a: 1 cycle; ready_out low from accept until the ack has been withdrawn.
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk_b,
  input  logic             rst_b,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready_out,
  output logic             req_a,
  output logic [WIDTH-1:0] data_a,
  input  logic             ack_a,
  output logic             done,
  output logic [7:0]       xfer_count
);

  state_t           state_q, state_d;
  logic             ack_s;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic [7:0]       cnt_q, cnt_d;

  cdc_bit_sync_n #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk_i(clk_b),
    .rst_i(rst_b),
    .d_i  (ack_a),
    .q_o  (ack_s)
  );

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in && !ack_s) state_d = REQ;
      REQ:     if (ack_s)              state_d = RELEASE;
      RELEASE: if (!ack_s)             state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // A stale ack left high in IDLE blocks acceptance until it has been withdrawn.
  always_comb begin
    ready_out = 1'b0;
    req_d     = req_q;
    data_d    = data_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        ready_out = !ack_s;
        if (valid_in && !ack_s) begin
          req_d  = 1'b1;
          data_d = data_in;
        end
      end
      REQ: begin
        if (ack_s) req_d = 1'b0;
      end
      RELEASE: begin
        if (!ack_s) begin
          done_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_b or posedge rst_b) begin
    if (rst_b) begin
      req_q  <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
    end
  end

  assign req_a      = req_q;
  assign data_a     = data_q;
  assign done       = done_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: a model domain-A receiver scores words against a queue of accepted offers.
module tb_cdc_handshake_tx;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk_b = 1'b0;
  logic         rst_b;
  logic         valid_in;
  logic [W-1:0] data_in;
  logic         ready_out;
  logic         req_a;
  logic [W-1:0] data_a;
  logic         ack_a;
  logic         done;
  logic [7:0]   xfer_count;

  int checks    = 0;
  int failures  = 0;
  int exp_q[$];
  int model_cnt = 0;
  int rx_n      = 0;
  bit rx_en     = 1'b0;
  bit rand_dly  = 1'b0;
  int ack_dly   = 3;
  int drop_dly  = 3;

  cdc_handshake_tx #(
    .WIDTH      (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk_b     (clk_b),
    .rst_b     (rst_b),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .req_a     (req_a),
    .data_a    (data_a),
    .ack_a     (ack_a),
    .done      (done),
    .xfer_count(xfer_count)
  );

  always #5 clk_b = ~clk_b;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_n < n && c < budget) begin
      @(negedge clk_b);
      c++;
    end
    chk("rx_complete", int'(rx_n >= n), 1);
  endtask

  // Offer one word for a single cycle; reports whether it was taken.
  task automatic offer(input logic [W-1:0] d, output bit taken);
    @(negedge clk_b);
    valid_in = 1'b1;
    data_in  = d;
    taken    = ready_out;
    if (taken) exp_q.push_back(int'(d));
    @(negedge clk_b);
    valid_in = 1'b0;
  endtask

  // Domain-A receiver: checks each presented word and the handshake timing.
  initial begin : rx_mon
    int w, e, k, ad, dd;
    bit hold_ok;
    forever begin
      @(negedge clk_b);
      if (rx_en && req_a) begin
        w = int'(data_a);
        e = (exp_q.size() == 0) ? -1 : exp_q.pop_front();
        chk("rx_word", w, e);
        ad = rand_dly ? int'($urandom_range(0, 3)) : ack_dly;
        dd = rand_dly ? int'($urandom_range(0, 3)) : drop_dly;
        hold_ok = 1'b1;
        repeat (ad) begin
          @(negedge clk_b);
          if (int'(data_a) != w || !req_a) hold_ok = 1'b0;
        end
        ack_a = 1'b1;
        k = 0;
        while (req_a && k < 20) begin
          @(negedge clk_b);
          k++;
          if (int'(data_a) != w) hold_ok = 1'b0;
        end
        chk("ack_to_req_fall", k, S + 1);
        repeat (dd) begin
          @(negedge clk_b);
          if (int'(data_a) != w) hold_ok = 1'b0;
        end
        ack_a = 1'b0;
        k = 0;
        while (!done && k < 20) begin
          @(negedge clk_b);
          k++;
          if (int'(data_a) != w) hold_ok = 1'b0;
        end
        chk("ackdrop_to_done", k, S + 1);
        chk("data_hold", int'(hold_ok), 1);
        model_cnt = (model_cnt + 1) % 256;
        chk("xfer_count", int'(xfer_count), model_cnt);
        chk("ready_at_done", int'(ready_out), 1);
        rx_n++;
        @(negedge clk_b);
        chk("done_width", int'(done), 0);
      end
    end
  end

  initial begin : main
    bit taken;
    int n_acc, cyc, i, base, k;

    rst_b    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    ack_a    = 1'b0;
    #22 rst_b = 1'b0;
    @(negedge clk_b);
    chk("rst_req_a", int'(req_a), 0);
    chk("rst_data_a", int'(data_a), 0);
    chk("rst_ready", int'(ready_out), 1);
    chk("rst_count", int'(xfer_count), 0);
    chk("rst_done", int'(done), 0);

    // Single transfer followed by an offer while busy.
    rx_en = 1'b1;
    ack_dly = 3;
    drop_dly = 3;
    offer(4'hA, taken);
    chk("single_taken", int'(taken), 1);
    chk("accept_req", int'(req_a), 1);
    chk("accept_ready_low", int'(ready_out), 0);
    offer(4'h5, taken);
    chk("busy_rejected", int'(taken), 0);
    wait_rx(1, 100);
    @(negedge clk_b);
    chk("single_data_kept", int'(data_a), 'hA);
    chk("single_count", int'(xfer_count), 1);
    chk("single_req_low", int'(req_a), 0);

    // Stale ack held across reset release.
    rx_en = 1'b0;
    @(negedge clk_b);
    ack_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk_b);
    rst_b = 1'b0;
    repeat (S + 1) @(negedge clk_b);
    chk("stale_ready", int'(ready_out), 0);
    offer(4'h3, taken);
    chk("stale_rejected", int'(taken), 0);
    chk("stale_no_req", int'(req_a), 0);
    ack_a = 1'b0;
    k = 0;
    while (!ready_out && k < 20) begin
      @(negedge clk_b);
      k++;
    end
    chk("stale_release_lat", k, S);
    chk("stale_still_no_req", int'(req_a), 0);
    model_cnt = 0;

    // Reset while req_a is high.
    offer(4'h9, taken);
    chk("midreq_taken", int'(taken), 1);
    exp_q.delete();
    chk("midreq_req_high", int'(req_a), 1);
    #2 rst_b = 1'b1;
    #1;
    chk("midreq_req_cleared", int'(req_a), 0);
    chk("midreq_data_cleared", int'(data_a), 0);
    #1 rst_b = 1'b0;
    @(negedge clk_b);
    chk("midreq_idle_ready", int'(ready_out), 1);
    chk("midreq_count", int'(xfer_count), 0);

    // Random offers against a receiver with random response delays.
    rx_en = 1'b1;
    rand_dly = 1'b1;
    n_acc = 0;
    cyc = 0;
    base = rx_n;
    while (n_acc < 20 && cyc < 3000) begin
      @(negedge clk_b);
      valid_in = 1'($urandom_range(0, 1));
      data_in  = W'($urandom);
      if (valid_in && ready_out) begin
        exp_q.push_back(int'(data_in));
        n_acc++;
      end
      cyc++;
    end
    @(negedge clk_b);
    valid_in = 1'b0;
    chk("rand_accepts", n_acc, 20);
    wait_rx(base + 20, 1000);
    chk("rand_queue_empty", exp_q.size(), 0);

    // 256 back-to-back transfers from a fresh reset; count must wrap to 0.
    rx_en = 1'b0;
    rand_dly = 1'b0;
    ack_dly = 0;
    drop_dly = 0;
    repeat (2) @(negedge clk_b);
    rst_b = 1'b1;
    @(negedge clk_b);
    rst_b = 1'b0;
    model_cnt = 0;
    base = rx_n;
    rx_en = 1'b1;
    i = 0;
    cyc = 0;
    while (i < 256 && cyc < 6000) begin
      @(negedge clk_b);
      valid_in = 1'b1;
      data_in  = W'(i % 16);
      if (ready_out) begin
        exp_q.push_back(i % 16);
        i++;
      end
      cyc++;
    end
    @(negedge clk_b);
    valid_in = 1'b0;
    chk("b2b_accepts", i, 256);
    wait_rx(base + 256, 3000);
    repeat (2) @(negedge clk_b);
    chk("b2b_wrap", int'(xfer_count), 0);
    chk("b2b_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
